apu_reg_tx: RTL and testbench



---
 rtl/chiptune_pkg.sv | 25 ++
 rtl/apu_reg_tx_if.sv | 13 +
 rtl/uart_baud_tick.sv | 29 ++
 rtl/apu_reg_tx.sv | 124 ++++++++++++
 tb/tb_apu_reg_tx.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/chiptune_pkg.sv
// Shared definitions for the chiptune register-write serial link.
package chiptune_pkg;

  localparam int unsigned CLKRATE_DEFAULT  = 1_790_000;
  localparam int unsigned BAUDRATE_DEFAULT = 9600;
  localparam int unsigned ADDR_W           = 4;
  localparam int unsigned BYTE_W           = 8;

  // High nibble that marks an address byte on the wire
  localparam logic [3:0] ADDR_TAG = 4'h8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Clocks per bit, rounded to nearest
  function automatic int unsigned calc_divisor(input int unsigned clkrate,
                                               input int unsigned baudrate);
    return (clkrate + baudrate / 2) / baudrate;
  endfunction

endpackage

// File: rtl/apu_reg_tx_if.sv
// Register-write handshake between a sequencer and the serial transmitter.
interface apu_reg_tx_if;
  import chiptune_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [BYTE_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Clearable bit-period counter; tick_c is high for the last cycle of each bit.
module uart_baud_tick #(
  parameter int unsigned DIVISOR = 186
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..DIVISOR-1, held at zero while cleared
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_c = !clear && (cnt == LAST);

endmodule

// File: rtl/apu_reg_tx.sv
// Serial transmitter for APU register writes: each write goes out as an
// address byte {ADDR_TAG, addr} followed by the data byte, 8N1, LSB first.
// Build option APU_REG_TX_TWO_STOP_EN: two stop bits per byte.
module apu_reg_tx
  import chiptune_pkg::*;
#(
  parameter int unsigned CLKRATE  = CLKRATE_DEFAULT,
  parameter int unsigned BAUDRATE = BAUDRATE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  apu_reg_tx_if.slave      wr,
  output logic             tx,
  output logic             busy
);

  localparam int unsigned DIVISOR  = calc_divisor(CLKRATE, BAUDRATE);
  localparam logic [2:0]  LAST_BIT = 3'd7;

  tx_state_e         state;
  logic [BYTE_W-1:0] shift;
  logic [BYTE_W-1:0] data_q;
  logic [2:0]        bit_idx;
  logic              byte_sel;
  logic              baud_clear_c;
  logic              tick_c;
  logic              stop_done_c;

`ifdef APU_REG_TX_TWO_STOP_EN
  logic              stop_cnt;
  assign stop_done_c = tick_c && stop_cnt;
`else
  assign stop_done_c = tick_c;
`endif

  // Bit timer restarts from zero on every accept so the start bit is full width
  assign baud_clear_c = (state == IDLE);

  uart_baud_tick #(
    .DIVISOR (DIVISOR)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (baud_clear_c),
    .tick_c (tick_c)
  );

  // Frame sequencer with registered tx/handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx          <= 1'b1;
      wr.wr_ready <= 1'b1;
      busy        <= 1'b0;
      shift       <= '0;
      data_q      <= '0;
      bit_idx     <= '0;
      byte_sel    <= 1'b0;
`ifdef APU_REG_TX_TWO_STOP_EN
      stop_cnt    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (wr.wr_valid && wr.wr_ready) begin
            shift       <= {ADDR_TAG, wr.wr_addr};
            data_q      <= wr.wr_data;
            byte_sel    <= 1'b0;
            state       <= START;
            tx          <= 1'b0;
            wr.wr_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        START: begin
          if (tick_c) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end
        DATA: begin
          if (tick_c) begin
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
              tx    <= 1'b1;
`ifdef APU_REG_TX_TWO_STOP_EN
              stop_cnt <= 1'b0;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[BYTE_W-1:1]};
              tx      <= shift[1];
            end
          end
        end
        STOP: begin
`ifdef APU_REG_TX_TWO_STOP_EN
          if (tick_c) begin
            stop_cnt <= ~stop_cnt;
          end
`endif
          if (stop_done_c) begin
            if (!byte_sel) begin
              byte_sel <= 1'b1;
              shift    <= data_q;
              state    <= START;
              tx       <= 1'b0;
            end else begin
              state       <= IDLE;
              tx          <= 1'b1;
              wr.wr_ready <= 1'b1;
              busy        <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apu_reg_tx.sv
// Bench for apu_reg_tx: per-cycle waveform model plus mid-bit decoding of frames.
module tb_apu_reg_tx;
  import chiptune_pkg::*;

  localparam int D = int'(calc_divisor(CLKRATE_DEFAULT, BAUDRATE_DEFAULT));
`ifdef APU_REG_TX_TWO_STOP_EN
  localparam int STOPS   = 2;
  localparam int EXP_LEN = 4092;
`else
  localparam int STOPS   = 1;
  localparam int EXP_LEN = 3720;
`endif
  localparam int BPB        = 9 + STOPS;
  localparam int FRAME_BITS = 2 * BPB;
  localparam int BUDGET     = 3 * FRAME_BITS * D;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx;
  logic busy;

  apu_reg_tx_if intf ();

  apu_reg_tx #(
    .CLKRATE  (1_790_000),
    .BAUDRATE (9600)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wr    (intf),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  logic mq[$];
  bit   m_ready  = 1'b1;
  bit   cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Expected tx level for every cycle of one frame
  task automatic push_frame(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] bytes [2];
    bytes[0] = {4'h8, a};
    bytes[1] = d;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < D; k++) mq.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < D; k++) mq.push_back(bytes[b][i]);
      for (int k = 0; k < STOPS * D; k++) mq.push_back(1'b1);
    end
  endtask

  // Model: a write is taken when it is offered while no frame is pending
  always @(posedge clk) begin
    if (reset) mq.delete();
    else if (m_ready && intf.wr_valid) push_frame(intf.wr_addr, intf.wr_data);
  end

  always @(negedge clk) begin
    bit   eb;
    logic et;
    if (cmp_en) begin
      eb = (mq.size() != 0);
      et = eb ? mq.pop_front() : 1'b1;
      check("tx", 32'(tx), 32'(et));
      check("busy", 32'(busy), 32'(eb));
      check("wr_ready", 32'(intf.wr_ready), 32'(!eb));
      m_ready = !eb;
    end
  end

  // Offer a write and return on the negedge just after it is accepted
  task automatic drive_write(input logic [3:0] a, input logic [7:0] d, input bit keep_valid);
    int n;
    n = 0;
    @(negedge clk);
    intf.wr_valid = 1'b1;
    intf.wr_addr  = a;
    intf.wr_data  = d;
    while (!intf.wr_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!intf.wr_ready) check("accept_timeout", 32'(intf.wr_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) intf.wr_valid = 1'b0;
    intf.wr_addr = 4'($urandom);
    intf.wr_data = 8'($urandom);
  endtask

  // Sample tx mid-bit from the negedge after accept; rdy = cycles until wr_ready
  task automatic capture(output logic [7:0] b0, output logic [7:0] b1, output bit ok, output int rdy);
    logic [FRAME_BITS-1:0] fb;
    int cnt;
    cnt = 0;
    ok  = 1'b1;
    for (int j = 0; j < FRAME_BITS; j++) begin
      while (cnt < D / 2 + j * D) begin
        @(negedge clk);
        cnt++;
      end
      fb[j] = tx;
    end
    while (!intf.wr_ready && cnt < BUDGET) begin
      @(negedge clk);
      cnt++;
    end
    rdy = cnt;
    for (int k = 0; k < 2; k++) begin
      if (fb[k*BPB] !== 1'b0) ok = 1'b0;
      for (int s = 0; s < STOPS; s++)
        if (fb[k*BPB+9+s] !== 1'b1) ok = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      b0[i] = fb[1+i];
      b1[i] = fb[BPB+1+i];
    end
  endtask

  logic [7:0] b0, b1;
  bit         ok;
  int         rdy;

  initial begin
    intf.wr_valid = 1'b0;
    intf.wr_addr  = '0;
    intf.wr_data  = '0;
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    repeat (1000) @(negedge clk);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_ready", 32'(intf.wr_ready), 32'd1);

    // Single write
    drive_write(4'h3, 8'hA5, 1'b0);
    check("t2_start_low", 32'(tx), 32'd0);
    capture(b0, b1, ok, rdy);
    check("t2_byte0", 32'(b0), 32'h83);
    check("t2_byte1", 32'(b1), 32'hA5);
    check("t2_framing", 32'(ok), 32'd1);
    check("t2_frame_len", 32'(rdy), 32'(EXP_LEN));

    // Back-to-back with wr_valid held
    drive_write(4'h0, 8'h3F, 1'b1);
    intf.wr_addr = 4'h1;
    intf.wr_data = 8'h08;
    capture(b0, b1, ok, rdy);
    check("t3_byte0", 32'(b0), 32'h80);
    check("t3_byte1", 32'(b1), 32'h3F);
    check("t3_frame_len", 32'(rdy), 32'(EXP_LEN));
    @(negedge clk);
    intf.wr_valid = 1'b0;
    check("t3_second_start", 32'(tx), 32'd0);
    capture(b0, b1, ok, rdy);
    check("t3_byte2", 32'(b0), 32'h81);
    check("t3_byte3", 32'(b1), 32'h08);
    check("t3_framing", 32'(ok), 32'd1);

    // Data changes after accept, request while busy ignored
    drive_write(4'h9, 8'h11, 1'b0);
    intf.wr_data = 8'hEE;
    fork
      capture(b0, b1, ok, rdy);
      begin
        repeat (500) @(negedge clk);
        intf.wr_valid = 1'b1;
        @(negedge clk);
        intf.wr_valid = 1'b0;
      end
    join
    check("t4_byte0", 32'(b0), 32'h89);
    check("t4_byte1", 32'(b1), 32'h11);
    repeat (2 * D) @(negedge clk);
    check("t4_no_extra", 32'(busy), 32'd0);

    // Reset mid-frame, with a request offered during reset
    drive_write(4'h5, 8'h5A, 1'b0);
    repeat (999) @(negedge clk);
    reset = 1'b1;
    intf.wr_valid = 1'b1;
    @(negedge clk);
    check("t5_tx_after_reset", 32'(tx), 32'd1);
    check("t5_busy_after_reset", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    intf.wr_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_no_accept_in_reset", 32'(busy), 32'd0);
    drive_write(4'hF, 8'h00, 1'b0);
    capture(b0, b1, ok, rdy);
    check("t5_byte0", 32'(b0), 32'h8F);
    check("t5_byte1", 32'(b1), 32'h00);
    check("t5_framing", 32'(ok), 32'd1);

    // Unused slot passes unchanged
    drive_write(4'hD, 8'h5C, 1'b0);
    capture(b0, b1, ok, rdy);
    check("t6_byte0", 32'(b0), 32'h8D);
    check("t6_byte1", 32'(b1), 32'h5C);

`ifdef APU_REG_TX_TWO_STOP_EN
    drive_write(4'h8, 8'hFF, 1'b0);
    capture(b0, b1, ok, rdy);
    check("t7_byte0", 32'(b0), 32'h88);
    check("t7_byte1", 32'(b1), 32'hFF);
    check("t7_framing", 32'(ok), 32'd1);
    check("t7_frame_len", 32'(rdy), 32'd4092);
`endif

    // Randomized writes against the model
    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(0, 30)) @(negedge clk);
      drive_write(4'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    intf.wr_valid = 1'b0;
    begin
      int n;
      n = 0;
      while ((busy || mq.size() != 0) && n < BUDGET * 2) begin
        @(negedge clk);
        n++;
      end
      check("final_idle", 32'(busy), 32'd0);
    end
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
